// File: rtl/rs232_pkg.sv
// rs232_pkg: shared types and elaboration helpers for the RS-232 transmitter.
//   parity_e     : frame parity mode (matches the integer PARITY parameter)
//   state_e      : transmitter FSM states
//   baud_divisor : rounded clock cycles per bit
package rs232_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Round to nearest so the bit period error stays within half a clock.
  function automatic int baud_divisor(input int clock_freq, input int baud_rate);
    return (clock_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty flags.
//   clock, reset : clock, synchronous active-high reset (empties the FIFO)
//   i_push/i_wdata : write request; ignored while full, even if popping
//   i_pop/o_rdata  : read request; o_rdata shows the head entry (fall-through)
//   o_full/o_empty : registered status flags
//   o_level        : occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [LW-1:0]    r_level;
  logic             r_full, r_empty;
  logic             w_push_ok, w_pop_ok;
  logic [LW-1:0]    w_level_n;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign w_push_ok = i_push & ~r_full;
  assign w_pop_ok  = i_pop & ~r_empty;

  always_comb begin
    w_level_n = r_level;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_level_n = r_level + LW'(1);
      2'b01:   w_level_n = r_level - LW'(1);
      default: w_level_n = r_level;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push_ok) r_wp <= r_wp + AW'(1);
      if (w_pop_ok)  r_rp <= r_rp + AW'(1);
      r_level <= w_level_n;
      r_full  <= (w_level_n == LW'(DEPTH));
      r_empty <= (w_level_n == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wp] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rp];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/rs232_tx.sv
// rs232_tx: FIFO-buffered RS-232 transmitter with CTS flow control.
//   clock, reset : clock, synchronous active-high reset
//   data/valid/ready : push interface into the input FIFO
//   txd   : serial line, idle high
//   cts_n : asynchronous active-low clear-to-send, checked between frames
//   busy  : high from the pop cycle through the last stop-bit cycle
//   level : FIFO occupancy
module rs232_tx
  import rs232_pkg::*;
#(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          valid,
  output logic                          ready,
  output logic                          txd,
  input  logic                          cts_n,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int             DIVISOR  = baud_divisor(CLOCK_FREQ, BAUD_RATE);
  localparam int             CW       = $clog2(DIVISOR);
  localparam logic [CW-1:0]  BIT_LAST = CW'(DIVISOR - 1);
  localparam int             BW       = 4;
  localparam bit             HAS_PAR  = (PARITY != int'(PAR_NONE));
  localparam bit             ODD_PAR  = (PARITY == int'(PAR_ODD));

  logic                 r_cts_s1, r_cts_s2;
  logic                 w_cts_ok, w_full, w_empty, w_pop, w_tick;
  logic [DATA_BITS-1:0] w_rdata;

  state_e               r_state, w_state_n;
  logic [CW-1:0]        r_cnt, w_cnt_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 r_par, w_par_n;
  logic [BW-1:0]        r_bit, w_bit_n;
  logic                 r_txd, w_txd_n;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (valid & ready),
    .i_wdata (data),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign ready    = ~w_full;
  assign w_cts_ok = ~r_cts_s2;
  assign w_pop    = (r_state == ST_IDLE) & ~w_empty & w_cts_ok;
  assign w_tick   = (r_cnt == '0);
  assign busy     = (r_state != ST_IDLE) | w_pop;
  assign txd      = r_txd;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_bit_n   = r_bit;
    // Bit timer free-runs inside a frame; every zero is a bit boundary.
    if (r_state != ST_IDLE) w_cnt_n = w_tick ? BIT_LAST : r_cnt - CW'(1);
    case (r_state)
      ST_IDLE: if (w_pop) begin
        w_state_n = ST_START;
        w_cnt_n   = BIT_LAST;
        w_shift_n = w_rdata;
        w_par_n   = ODD_PAR ? ~^w_rdata : ^w_rdata;
      end
      ST_START: if (w_tick) begin
        w_state_n = ST_DATA;
        w_bit_n   = '0;
      end
      ST_DATA: if (w_tick) begin
        w_shift_n = r_shift >> 1;
        if (r_bit == BW'(DATA_BITS - 1)) begin
          w_state_n = HAS_PAR ? ST_PARITY : ST_STOP;
          w_bit_n   = '0;
        end else begin
          w_bit_n = r_bit + BW'(1);
        end
      end
      ST_PARITY: if (w_tick) begin
        w_state_n = ST_STOP;
        w_bit_n   = '0;
      end
      ST_STOP: if (w_tick) begin
        if (r_bit == BW'(STOP_BITS - 1)) w_state_n = ST_IDLE;
        else                             w_bit_n   = r_bit + BW'(1);
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Line level follows the next state so txd is a clean flop output.
  always_comb begin
    case (w_state_n)
      ST_START:  w_txd_n = 1'b0;
      ST_DATA:   w_txd_n = w_shift_n[0];
      ST_PARITY: w_txd_n = w_par_n;
      default:   w_txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cts_s1 <= 1'b1;
      r_cts_s2 <= 1'b1;
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_bit    <= '0;
      r_txd    <= 1'b1;
    end else begin
      r_cts_s1 <= cts_n;
      r_cts_s2 <= r_cts_s1;
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_shift  <= w_shift_n;
      r_par    <= w_par_n;
      r_bit    <= w_bit_n;
      r_txd    <= w_txd_n;
    end
  end

endmodule

// File: doc/rs232_tx.md
# rs232_tx

Parametrised RS-232 transmitter for the FT232 serial link: configurable frame format, an input FIFO with a valid/ready handshake, and CTS hardware flow control. It replaces the free-running test pattern currently driven onto `ft232_rxd`. Host-side logic pushes words in, and the block serialises them onto `txd`. Transmission pauses between frames whenever the FT232 deasserts CTS.

## Interface
- `CLOCK_FREQ`, default 133000000: clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- `DATA_BITS`, default 8: data bits per frame, 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 4: input FIFO entries; power of two, ≥2.
- `clock`  in  1  single clock. Reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `data`  in  DATA_BITS  word to send.
- `valid`  in  1  `data` is valid this cycle.
- `ready`  out  1  FIFO can accept a word this cycle.
- `txd`  out  1  serial output to the FT232; idle level is high.
- `cts_n`  in  1  clear-to-send from the FT232, active-low, asynchronous.
- `busy`  out  1  a frame is on the line.
- `level`  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- `DIVISOR = (CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE`. Rounded, computed at elaboration, must be ≥2. Defaults give 1155.
- Push: a word is written when `valid && ready`. `ready = (level != FIFO_DEPTH)` and is registered. A push while full is dropped and `level` does not change.
- `cts_n` passes through a 2-flop synchroniser; the result is `cts_ok = !cts_n_sync`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO non-empty and `cts_ok`, pop the word into the shift register and go to START.
  - START: `txd = 0` for one bit time.
  - DATA: LSB first, DATA_BITS bit times.
  - PARITY: present only if PARITY≠0. Odd: total ones in data+parity is odd. Even: total ones is even.
  - STOP: `txd = 1` for STOP_BITS bit times, then back to IDLE.
- Bit timer: counts DIVISOR−1 down to 0 and reloads on frame start and on every bit boundary.
- Flow control is checked only in IDLE. A frame already started always completes, even if CTS deasserts mid-frame.
- Push and pop may happen in the same cycle. Push-while-full is dropped even if a pop happens in that cycle. `level` updates by +1, −1 or 0.
- Reset: `txd=1`, `busy=0`, `ready=1`, `level=0`. FIFO is emptied, FSM goes to IDLE, synchroniser is cleared to "not clear". Reset mid-frame truncates the frame with `txd` high on the next edge. Pushes during reset are ignored.

## Timing
- Cycle 0: push into an empty FIFO with `cts_ok` already high.
- Cycle 1: pop; `busy` rises.
- Cycle 2: `txd` falls (start bit). Each bit lasts exactly DIVISOR cycles.
- Frame length is `(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIVISOR` cycles.
- Back-to-back frames: when the FIFO is non-empty and `cts_ok` is high at the end of the last stop bit, the next start bit follows with at most one idle cycle of `txd=1`.
- `busy` is high from the pop cycle through the last stop-bit cycle.
- `cts_n` to effect latency: 2–3 cycles.

## Structure
- Package `rs232_pkg`:
  - parity enum (NONE/ODD/EVEN);
  - FSM state enum;
  - function `baud_divisor(clock_freq, baud_rate)`.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): registered full/empty flags and a level output.
- The FSM, bit timer and shift register stay in `rs232_tx`.

## Test plan
- CLOCK_FREQ=16, BAUD_RATE=1 (DIVISOR=16), 8N1, `cts_n=0`: push 0x55 → `txd` reads 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles; start bit at cycle 2; `busy` low again after 160 cycles.
- Same clocking, 7O2: push 0x03 → 0, 1,1,0,0,0,0,0, parity 1, stop 1,1; frame is 176 cycles.
- FIFO_DEPTH=4, `cts_n=1`: push 5 words → `ready` drops after 4, the 5th word is dropped, `level=4`, `txd` stays high. Then drive `cts_n=0` → 4 frames back-to-back, gap ≤1 cycle.
- CTS mid-frame: raise `cts_n` during a data bit → current frame completes. The next queued frame starts only 2–3 cycles after `cts_n` returns low.
- Simultaneous push and pop at `level=1` → `level` stays 1. Push while full with a same-cycle pop → word dropped, `level` becomes 3.
- Assert `reset` during bit 3 → next cycle `txd=1`, `busy=0`, `level=0`, `ready=1`. A push during reset is ignored.
